// File: rtl/walk_signal_controller.sv
// Pedestrian crossing sequencer: walk-sign code plus road lamps,
// stepped through green/yellow/red/walk/flash/red on tick-based dwells.
module walk_signal_controller #(
  parameter int unsigned MIN_GREEN    = 8,
  parameter int unsigned YELLOW_TIME  = 3,
  parameter int unsigned ALL_RED_TIME = 2,
  parameter int unsigned WALK_TIME    = 6,
  parameter int unsigned FLASH_TIME   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_request,
  input  logic       enable,
  output logic [2:0] state,
  output logic       road_red,
  output logic       road_yellow,
  output logic       road_green,
  output logic       request_pending
);

  typedef enum logic [2:0] {
    GREEN, YELLOW, RED1, WALK, FLASH, RED2
  } fsm_t;

  localparam logic [7:0] MG_M1 = 8'(MIN_GREEN - 1);
  localparam logic [7:0] YL_M1 = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] AR_M1 = 8'(ALL_RED_TIME - 1);
  localparam logic [7:0] WK_M1 = 8'(WALK_TIME - 1);
  localparam logic [7:0] FL_M1 = 8'(FLASH_TIME - 1);

  localparam logic [2:0] S_OFF   = 3'b000;
  localparam logic [2:0] S_DW    = 3'b001;
  localparam logic [2:0] S_FLASH = 3'b010;
  localparam logic [2:0] S_WALK  = 3'b100;

  fsm_t       st, st_n, adv;
  logic [7:0] tmr, tmr_n, lim;
  logic       gd, gd_n;
  logic       timed;
  logic       svc;
  logic       req_n, yel_n;
  logic [2:0] code_n;
  logic       red_n, grn_n;

  always_comb begin
    st_n  = st;
    tmr_n = tmr;
    gd_n  = gd;
    timed = 1'b0;
    lim   = '0;
    adv   = GREEN;
    case (st)
      GREEN: begin
        if (gd && request_pending) begin
          st_n  = YELLOW;
          tmr_n = '0;
          gd_n  = 1'b0;
        end else if (tick && !gd) begin
          tmr_n = tmr + 8'd1;
          gd_n  = (tmr == MG_M1);
        end
      end
      YELLOW: begin timed = 1'b1; lim = YL_M1; adv = RED1;  end
      RED1:   begin timed = 1'b1; lim = AR_M1; adv = WALK;  end
      WALK:   begin timed = 1'b1; lim = WK_M1; adv = FLASH; end
      FLASH:  begin timed = 1'b1; lim = FL_M1; adv = RED2;  end
      RED2:   begin timed = 1'b1; lim = AR_M1; adv = GREEN; end
      default: begin
        st_n  = GREEN;
        tmr_n = '0;
        gd_n  = 1'b0;
      end
    endcase
    if (timed && tick) begin
      if (tmr == lim) begin
        st_n  = adv;
        tmr_n = '0;
      end else begin
        tmr_n = tmr + 8'd1;
      end
    end
    if (!enable) begin
      st_n  = GREEN;
      tmr_n = '0;
      gd_n  = 1'b0;
    end
  end

  // Requests are dropped while walking and on the edge that starts the walk
  always_comb begin
    req_n = enable && (st != WALK) && (st_n != WALK)
            && (request_pending || ped_request);
    yel_n = 1'b0;
    if (!enable)
      yel_n = svc ? (road_yellow ^ tick) : 1'b1;
    else
      yel_n = (st_n == YELLOW);
  end

  always_comb begin
    code_n = S_DW;
    red_n  = 1'b0;
    grn_n  = 1'b0;
    case (st_n)
      GREEN:  grn_n = 1'b1;
      YELLOW: ;
      WALK:   begin code_n = S_WALK;  red_n = 1'b1; end
      FLASH:  begin code_n = S_FLASH; red_n = 1'b1; end
      default: red_n = 1'b1;
    endcase
    if (!enable) begin
      code_n = S_OFF;
      red_n  = 1'b0;
      grn_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st              <= GREEN;
      tmr             <= '0;
      gd              <= 1'b0;
      svc             <= 1'b0;
      request_pending <= 1'b0;
      state           <= S_DW;
      road_red        <= 1'b0;
      road_yellow     <= 1'b0;
      road_green      <= 1'b1;
    end else begin
      st              <= st_n;
      tmr             <= tmr_n;
      gd              <= gd_n;
      svc             <= !enable;
      request_pending <= req_n;
      state           <= code_n;
      road_red        <= red_n;
      road_yellow     <= yel_n;
      road_green      <= grn_n;
    end
  end

endmodule

// File: tb/tb_walk_signal_controller.sv
// Bench for walk_signal_controller: directed scenarios then random
// stimulus, every cycle compared against a phase-table reference model.
module tb_walk_signal_controller;

  localparam int MG = 4;

  logic       clk = 1'b0;
  logic       reset, tick, ped_request, enable;
  logic [2:0] state;
  logic       road_red, road_yellow, road_green, request_pending;

  walk_signal_controller #(
    .MIN_GREEN(4), .YELLOW_TIME(2), .ALL_RED_TIME(1),
    .WALK_TIME(3), .FLASH_TIME(2)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .ped_request(ped_request), .enable(enable),
    .state(state), .road_red(road_red),
    .road_yellow(road_yellow), .road_green(road_green),
    .request_pending(request_pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Phase list: green, yellow, red1, walk, flash, red2
  int         dwell [6] = '{0, 2, 1, 3, 2, 1};
  logic [2:0] code  [6] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b010, 3'b001};
  int   m_ph, m_left, m_gcnt;
  logic m_pend, m_svc, m_yel;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] expected();
    logic [2:0] c;
    logic r, y, g;
    if (m_svc) begin
      c = 3'b000; r = 1'b0; g = 1'b0; y = m_yel;
    end else begin
      c = code[m_ph];
      g = (m_ph == 0);
      y = (m_ph == 1);
      r = (m_ph >= 2);
    end
    return {1'b0, c, r, y, g, m_pend};
  endfunction

  task automatic model();
    int nph;
    if (reset) begin
      m_ph = 0; m_gcnt = 0; m_pend = 0; m_svc = 0; m_yel = 0;
      return;
    end
    if (!enable) begin
      m_yel  = m_svc ? (m_yel ^ tick) : 1'b1;
      m_svc  = 1;
      m_ph   = 0; m_gcnt = 0; m_pend = 0;
      return;
    end
    m_svc = 0;
    nph = m_ph;
    if (m_ph == 0) begin
      if (m_gcnt >= MG && m_pend) begin
        nph = 1; m_left = dwell[1];
      end else if (tick && m_gcnt < MG) begin
        m_gcnt++;
      end
    end else if (tick) begin
      m_left--;
      if (m_left == 0) begin
        nph = (m_ph + 1) % 6;
        m_left = dwell[nph];
        if (nph == 0) m_gcnt = 0;
      end
    end
    m_pend = (m_ph == 3 || nph == 3) ? 1'b0 : (m_pend | ped_request);
    m_ph = nph;
  endtask

  task automatic step(input string tag);
    tick = (cyc % 4 == 3);
    @(posedge clk);
    model();
    @(negedge clk);
    chk(tag, {1'b0, state, road_red, road_yellow, road_green,
              request_pending}, expected());
    cyc++;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic wait_phase(input int p, input string tag);
    int n = 0;
    while (m_ph != p && n < 200) begin
      step(tag);
      n++;
    end
    if (n >= 200) chk({tag, "_timeout"}, 8'd0, 8'd1);
  endtask

  task automatic press(input string tag);
    ped_request = 1'b1;
    step(tag);
    ped_request = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; ped_request = 1'b1; enable = 1'b1;
    m_ph = 0; m_left = 0; m_gcnt = 0; m_pend = 0; m_svc = 0; m_yel = 0;
    @(negedge clk);
    run(2, "reset");
    reset = 1'b0;
    step("rst_release");
    ped_request = 1'b0;
    run(20, "green_hold");
    press("seq_press");
    wait_phase(2, "seq_to_red1");
    ped_request = 1'b1;
    wait_phase(3, "walk_entry");
    run(2, "walk_press");
    ped_request = 1'b0;
    wait_phase(4, "to_flash");
    press("flash_press");
    wait_phase(0, "to_green");
    run(4, "min_green");
    wait_phase(3, "second_walk");
    wait_phase(4, "flash2");
    enable = 1'b0;
    run(20, "service");
    enable = 1'b1;
    run(3, "reenable");
    press("reen_press");
    wait_phase(1, "reen_yellow");
    wait_phase(3, "walk3");
    reset = 1'b1;
    step("mid_reset");
    reset = 1'b0;
    run(10, "post_reset");
    for (int i = 0; i < 1500; i++) begin
      ped_request = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      reset = ($urandom_range(0, 199) == 0);
      step("random");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/walk_signal_controller.md
# walk_signal_controller

Pedestrian-crossing sequencer producing the 3-bit one-hot walk-sign state `{walk, flashing_dont_walk, dont_walk}` consumed by the hex walk-sign display, plus the road red/yellow/green lamps for the same crossing. It latches pedestrian button presses and steps the road through its phases with tick-based dwell timers:

- green
- yellow
- all-red
- walk
- flashing don't-walk
- all-red

A service-mode input blanks the walk sign and flashes the road yellow lamp.

## Interface

Parameters (all durations are counted in `tick` pulses, legal range 1..255):
- `MIN_GREEN`, default 8: minimum road-green dwell before a request is served.
- `YELLOW_TIME`, default 3: road-yellow dwell.
- `ALL_RED_TIME`, default 2: dwell of each all-red clearance phase.
- `WALK_TIME`, default 6: WALK dwell.
- `FLASH_TIME`, default 5: flashing don't-walk dwell.

Ports (clock and reset first):
- `clk`, input, 1: system clock. This is the only clock.
- `reset`, input, 1: synchronous, active-high reset.
- `tick`, input, 1: single-cycle timebase enable, synchronous to `clk`.
- `ped_request`, input, 1: pedestrian button, already debounced, level-sampled every `clk`.
- `enable`, input, 1: 1 = normal sequencing, 0 = service mode.
- `state`, output, 3: walk-sign code, registered. Legal values:
  - 3'b000 OFF
  - 3'b001 DONTWALK
  - 3'b010 FLASHINGDONTWALK
  - 3'b100 WALK
- `road_red`, `road_yellow`, `road_green`, output, 1 each: road lamps, registered. Exactly one is high except in service mode.
- `request_pending`, output, 1: latched pedestrian request, registered.

## Operation

FSM states, with their outputs:

| FSM state | `state` | Road lamp |
|---|---|---|
| GREEN | DONTWALK | green |
| YELLOW | DONTWALK | yellow |
| RED1 | DONTWALK | red |
| WALK | WALK | red |
| FLASH | FLASHINGDONTWALK | red |
| RED2 | DONTWALK | red |

Dwell timer:
- The dwell timer is 8 bits. It is cleared on every state transition.
- It increments on each `tick` while in a timed state.
- A timed state (YELLOW, RED1, WALK, FLASH, RED2) exits on the `clk` edge where `tick`=1 and timer == PARAM-1. Dwell is therefore exactly PARAM ticks.
- Transition order: YELLOW→RED1→WALK→FLASH→RED2→GREEN.

GREEN state:
- In GREEN the timer counts ticks up to `MIN_GREEN` and then sets `green_done`. `green_done` holds until the state is exited.
- GREEN→YELLOW occurs on the first `clk` edge where `green_done`=1 and `request_pending`=1. No tick is required for this transition.
- With no request, GREEN holds indefinitely.

Request latch:
- `request_pending` is set on any `clk` edge where `ped_request`=1, except while in WALK or on the edge entering WALK.
- It is cleared on the edge entering WALK. Clear wins over set.
- Presses during FLASH or RED2 remain pending and are served in the next cycle of the sequence, after `MIN_GREEN`.

Service mode (`enable`=0):
- The FSM is forced to GREEN with timer = 0 and `green_done` = 0.
- `request_pending` is held at 0.
- `state` = OFF.
- `road_red` = 0 and `road_green` = 0.
- `road_yellow` toggles on each `tick`, starting from 1 on the first cycle of service mode.
- When `enable` returns to 1, the next edge resumes at GREEN with a fresh `MIN_GREEN` count and `road_yellow` = 0.

Reset has priority over everything:
- The FSM goes to GREEN with timer = 0 and `green_done` = 0.
- `state` = 3'b001, `road_green` = 1, `road_red` = 0, `road_yellow` = 0, `request_pending` = 0.
- This applies regardless of `enable`. Service mode takes effect on the first edge after reset if `enable`=0.

## Timing

- All outputs are registered and change only on `clk` rising edges. There is no combinational input-to-output path.
- Outputs reflect the new FSM state in the same cycle the state register updates, because outputs are decoded into registers from the next-state value.
- `ped_request`→`request_pending`: 1 cycle.
- GREEN exit: 1 cycle after both `green_done` and `request_pending` are high.
- A `tick` on the same edge as a GREEN→YELLOW transition is not counted toward YELLOW.
- A `tick` coincident with reset or with `enable`=0 is ignored by the dwell timer.
- If a reset occurs mid-sequence, for example in WALK, the response is immediate return to GREEN/DONTWALK on that edge with no clearance phases.
- Timer compare uses PARAM-1 computed at elaboration. PARAM=1 exits on the first tick in the state.
- Outputs never show an illegal `state` code. The FSM default branch recovers to GREEN.

## Test plan

Bench parameters: `MIN_GREEN`=4, `YELLOW_TIME`=2, `ALL_RED_TIME`=1, `WALK_TIME`=3, `FLASH_TIME`=2, `tick` every 4th `clk`.

1. **Reset values.** Assert `reset` for 2 cycles with `ped_request`=1. Required: `state`=001, `road_green`=1, `road_red`=0, `road_yellow`=0 and `request_pending`=0 during reset; `request_pending`=1 one cycle after release.
2. **Full sequence.** Pulse `ped_request` after 5 ticks in GREEN. Required: YELLOW follows 1 cycle after `request_pending`, then exactly 2 ticks YELLOW, 1 RED1, 3 WALK (`state`=100), 2 FLASH (`state`=010), 1 RED2, then GREEN with `state`=001. `request_pending` falls on WALK entry.
3. **Minimum green and late requests.** A press 1 tick after entering GREEN holds green until the 4th tick. A press during WALK is ignored and `request_pending` stays 0 after RED2. A press during FLASH is held and triggers a new cycle 4 ticks after GREEN re-entry.
4. **Simultaneous events.** `ped_request`=1 on the WALK-entry edge leaves `request_pending`=0. A tick coincident with the GREEN→YELLOW edge does not count, so YELLOW still lasts 2 full ticks.
5. **Service mode.** Drop `enable` during FLASH. Required: `state`=000, red/green lamps 0, `road_yellow` starts at 1 and toggles each tick. On re-enable: GREEN, `road_yellow`=0, and a new request needs 4 ticks.
6. **Mid-operation reset.** Reset in WALK. Required: next edge shows GREEN/DONTWALK with `request_pending`=0 and no RED2 phase.
